// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction prefetcher with an in-order, PC-tagged response queue.
// Define IFU_BYPASS_EN to forward a response straight to decode when it lands on the head slot.
module ifu_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_inst_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 4;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0]      slot_pc   [DEPTH];
  logic [31:0]      slot_inst [DEPTH];
  logic [DEPTH-1:0] slot_full;

  ptr_t        head;
  ptr_t        tail;
  ptr_t        fptr;
  logic [AW:0] alloc;
  cnt_t        outst;
  cnt_t        disc;
  logic [31:0] fetch_pc;
  logic [31:0] last_pc;
  logic        run;

  logic grant;
  logic pop;
  logic fill;
  logic head_full;
  logic byp;

  // run keeps req low for the first cycle out of reset
  assign imem_req_o  = run && (alloc < (AW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o && imem_gnt_i;
  assign fill        = imem_rvalid_i && (disc == '0);
  assign head_full   = slot_full[head];

`ifdef IFU_BYPASS_EN
  assign byp = fill && (alloc != '0) && (fptr == head) && !head_full;
`else
  assign byp = 1'b0;
`endif

  assign out_valid_o = head_full || byp;
  assign out_pc_o    = out_valid_o ? slot_pc[head] : last_pc;
  assign out_inst_o  = head_full ? slot_inst[head] :
                       (byp ? imem_rdata_i : NOP_INST);
  assign pop         = out_valid_o && out_ready_i && !redirect_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run       <= 1'b0;
      head      <= '0;
      tail      <= '0;
      fptr      <= '0;
      alloc     <= '0;
      outst     <= '0;
      disc      <= '0;
      slot_full <= '0;
      fetch_pc  <= RESET_PC;
      last_pc   <= '0;
    end else begin
      run   <= 1'b1;
      outst <= outst + cnt_t'(grant) - cnt_t'(imem_rvalid_i);
      if (out_valid_o) last_pc <= out_pc_o;
      if (redirect_i) begin
        // every response still owed, including this cycle's grant, is dropped
        head      <= '0;
        tail      <= '0;
        fptr      <= '0;
        alloc     <= '0;
        slot_full <= '0;
        disc      <= outst + cnt_t'(grant) - cnt_t'(imem_rvalid_i);
        fetch_pc  <= redirect_pc_i & ~32'h3;
      end else begin
        if (grant) begin
          tail     <= tail + 1'b1;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (imem_rvalid_i && (disc != '0)) disc <= disc - 1'b1;
        if (fill) begin
          fptr            <= fptr + 1'b1;
          slot_full[fptr] <= 1'b1;
        end
        // a bypassed head pops here, so this clear overrides the fill above
        if (pop) begin
          head            <= head + 1'b1;
          slot_full[head] <= 1'b0;
        end
        alloc <= alloc + (AW+1)'(grant) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant && !redirect_i) slot_pc[tail] <= fetch_pc;
    if (fill && !redirect_i) slot_inst[fptr] <= imem_rdata_i;
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: scoreboard bench for ifu_prefetch with an in-order memory model.
// Build with IFU_BYPASS_EN defined to expect the one-cycle bypass latency.
module tb_ifu_prefetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XOR = 32'hA5A5_0000;
`ifdef IFU_BYPASS_EN
  localparam int LAT_EXP = 1;
`else
  localparam int LAT_EXP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;

  logic        redirect2 = 1'b0;
  logic [31:0] rpc2 = '0;
  logic        req2;
  logic [31:0] addr2;
  logic        gnt2 = 1'b1;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        valid2;
  logic        ready2 = 1'b1;
  logic [31:0] pc2;
  logic [31:0] inst2;

  always #5 clk = ~clk;

  ifu_prefetch dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
    .out_inst_o(out_inst_o)
  );

  ifu_prefetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst),
    .redirect_i(redirect2), .redirect_pc_i(rpc2),
    .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_gnt_i(gnt2), .imem_rvalid_i(rvalid2),
    .imem_rdata_i(rdata2), .out_valid_o(valid2),
    .out_ready_i(ready2), .out_pc_o(pc2),
    .out_inst_o(inst2)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } pair_t;
  typedef struct packed { logic [31:0] got; logic [31:0] exp; } aref_t;
  typedef struct { pair_t exp; pair_t got; bit has_exp; } chk_t;

  mreq_t       mem_q[$];
  pair_t       exp_q[$];
  chk_t        chk_q[$];
  aref_t       glog[$];
  logic [31:0] glog2[$];

  int          cyc;
  int          lat;
  int          s_cyc;
  logic        k_ready, k_gnt, k_redir;
  logic [31:0] k_rpc;
  logic [31:0] model_pc;
  logic        s_req, s_valid, s_rvalid, s_gnt, s_redir;
  logic [31:0] s_addr, s_pc, s_inst;
  int          errors = 0;
  int          checks = 0;

  task automatic step();
    logic  g;
    logic  p;
    chk_t  c;
    @(negedge clk);
    imem_gnt_i    = k_gnt;
    out_ready_i   = k_ready;
    redirect_i    = k_redir;
    redirect_pc_i = k_rpc;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_q[0].addr ^ XOR;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end
    #1;
    s_cyc = cyc; s_req = imem_req_o; s_addr = imem_addr_o;
    s_valid = out_valid_o; s_pc = out_pc_o; s_inst = out_inst_o;
    s_rvalid = imem_rvalid_i; s_gnt = imem_gnt_i; s_redir = redirect_i;
    g = imem_req_o && imem_gnt_i;
    p = out_valid_o && out_ready_i && !redirect_i;
    if (imem_rvalid_i) void'(mem_q.pop_front());
    if (g) begin
      mem_q.push_back('{imem_addr_o, cyc + lat});
      glog.push_back('{imem_addr_o, model_pc});
    end
    if (p) begin
      c.got = '{out_pc_o, out_inst_o};
      c.has_exp = exp_q.size() > 0;
      if (c.has_exp) c.exp = exp_q.pop_front();
      else c.exp = '0;
      chk_q.push_back(c);
    end
    if (redirect_i) begin
      exp_q.delete();
      model_pc = k_rpc & ~32'h3;
    end else if (g) begin
      exp_q.push_back('{model_pc, model_pc ^ XOR});
      model_pc = model_pc + 32'd4;
    end
    if (req2 && gnt2) glog2.push_back(addr2);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_i = 1'b0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; out_ready_i = 1'b0;
    k_ready = 1'b1; k_gnt = 1'b1; k_redir = 1'b0; k_rpc = '0;
    lat = 1; cyc = 0; model_pc = '0;
    mem_q.delete(); exp_q.delete(); chk_q.delete();
    glog.delete(); glog2.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b0)
      begin errors++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0)
      begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr_o); end
    checks++; if (out_valid_o !== 1'b0)
      begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid_o); end
    checks++; if (out_pc_o !== 32'h0)
      begin errors++; $display("FAIL rst_pc: got %h want 0", out_pc_o); end
    checks++; if (out_inst_o !== NOP)
      begin errors++; $display("FAIL rst_inst: got %h want %h", out_inst_o, NOP); end
    checks++; if (addr2 !== 32'hFFFF_FFF8 || valid2 !== 1'b0 || pc2 !== 32'h0 || inst2 !== NOP)
      begin errors++; $display("FAIL rst_dut2: got addr %h valid %b pc %h inst %h", addr2, valid2, pc2, inst2); end
    rst = 1'b0;
    repeat (6) step();
    checks++; if (s_valid !== 1'b1)
      begin errors++; $display("FAIL pre_midrst_valid: got %b want 1", s_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid_o !== 1'b0 || imem_req_o !== 1'b0 || out_inst_o !== NOP || imem_addr_o !== 32'h0)
      begin errors++; $display("FAIL midrst: got valid %b req %b inst %h addr %h want 0 0 %h 0", out_valid_o, imem_req_o, out_inst_o, imem_addr_o, NOP); end
  endtask

  task automatic test_stream();
    int   first_req;
    int   first_val;
    int   npop;
    chk_t c;
    first_req = -1; first_val = -1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_req && first_req < 0) first_req = s_cyc;
      if (s_valid && first_val < 0) first_val = s_cyc;
    end
    checks++; if (first_req < 0 || first_val - first_req != LAT_EXP)
      begin errors++; $display("FAIL latency: got %0d want %0d", first_val - first_req, LAT_EXP); end
    npop = chk_q.size();
    checks++; if (npop != 20 - LAT_EXP)
      begin errors++; $display("FAIL throughput: got %0d pops want %0d", npop, 20 - LAT_EXP); end
    if (npop > 1) begin
      checks++; if (chk_q[0].got !== {32'h0, 32'hA5A5_0000} || chk_q[1].got !== {32'h4, 32'hA5A5_0004})
        begin errors++; $display("FAIL first_pairs: got %h %h", chk_q[0].got, chk_q[1].got); end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++; if (!c.has_exp || c.got !== c.exp)
        begin errors++; $display("FAIL stream_pair: got %h want %h", c.got, c.exp); end
    end
  endtask

  task automatic test_backpressure();
    chk_t  c;
    aref_t a;
    do_reset();
    k_ready = 1'b0;
    repeat (10) step();
    checks++; if (glog.size() != 4 || s_req !== 1'b0)
      begin errors++; $display("FAIL bp_grants: got %0d grants req %b want 4 0", glog.size(), s_req); end
    k_ready = 1'b1;
    repeat (10) step();
    if (chk_q.size() >= 4 && glog.size() >= 5) begin
      checks++; if (chk_q[0].got.pc !== 32'h0 || chk_q[1].got.pc !== 32'h4 ||
                    chk_q[2].got.pc !== 32'h8 || chk_q[3].got.pc !== 32'hC)
        begin errors++; $display("FAIL bp_order: got %h %h %h %h", chk_q[0].got.pc, chk_q[1].got.pc, chk_q[2].got.pc, chk_q[3].got.pc); end
      checks++; if (glog[4].got !== 32'h10)
        begin errors++; $display("FAIL bp_resume: got %h want 00000010", glog[4].got); end
    end else begin
      checks++; errors++;
      $display("FAIL bp_drain: got %0d pops %0d grants", chk_q.size(), glog.size());
    end
    while (glog.size() > 0) begin
      a = glog.pop_front();
      checks++; if (a.got !== a.exp)
        begin errors++; $display("FAIL bp_addr: got %h want %h", a.got, a.exp); end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++; if (!c.has_exp || c.got !== c.exp)
        begin errors++; $display("FAIL bp_pair: got %h want %h", c.got, c.exp); end
    end
  endtask

  task automatic test_redirect_late();
    int   guard;
    int   base;
    chk_t c;
    do_reset();
    lat = 3;
    guard = 0;
    while (glog.size() < 2 && guard < 20) begin step(); guard++; end
    checks++; if (glog.size() != 2)
      begin errors++; $display("FAIL rl_setup: got %0d grants want 2", glog.size()); end
    k_gnt = 1'b0; k_redir = 1'b1; k_rpc = 32'h0000_0102;
    step();
    k_gnt = 1'b1; k_redir = 1'b0;
    base = glog.size();
    repeat (15) step();
    checks++; if (glog.size() <= base || glog[base].got !== 32'h100)
      begin errors++; $display("FAIL rl_addr: got %h want 00000100", (glog.size() > base) ? glog[base].got : 32'hx); end
    checks++; if (chk_q.size() == 0 || chk_q[0].got !== {32'h100, 32'hA5A5_0100})
      begin errors++; $display("FAIL rl_first: got %h want 00000100a5a50100", (chk_q.size() > 0) ? chk_q[0].got : 64'hx); end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++; if (!c.has_exp || c.got !== c.exp)
        begin errors++; $display("FAIL rl_pair: got %h want %h", c.got, c.exp); end
    end
  endtask

  task automatic test_redirect_collide();
    int   base;
    chk_t c;
    do_reset();
    repeat (6) step();
    base = chk_q.size();
    k_redir = 1'b1; k_rpc = 32'h0000_0200;
    step();
    k_redir = 1'b0;
    checks++; if (!(s_req && s_gnt && s_rvalid && s_valid))
      begin errors++; $display("FAIL rc_setup: got req %b gnt %b rvalid %b valid %b want 1111", s_req, s_gnt, s_rvalid, s_valid); end
    step();
    checks++; if (s_valid !== 1'b0 || s_inst !== NOP)
      begin errors++; $display("FAIL rc_empty: got valid %b inst %h want 0 %h", s_valid, s_inst, NOP); end
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h200)
      begin errors++; $display("FAIL rc_refetch: got req %b addr %h want 1 00000200", s_req, s_addr); end
    repeat (8) step();
    checks++; if (chk_q.size() <= base || chk_q[base].got !== {32'h200, 32'hA5A5_0200})
      begin errors++; $display("FAIL rc_first: got %h", (chk_q.size() > base) ? chk_q[base].got : 64'hx); end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++; if (!c.has_exp || c.got !== c.exp)
        begin errors++; $display("FAIL rc_pair: got %h want %h", c.got, c.exp); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    do_reset();
    repeat (6) step();
    checks++; if (glog2.size() != 4)
      begin errors++; $display("FAIL wrap_count: got %0d want 4", glog2.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (glog2.size() <= i || glog2[i] !== want[i])
        begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, (glog2.size() > i) ? glog2[i] : 32'hx, want[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic        pr, pg, pd;
    logic [31:0] pa;
    int          npop;
    chk_t        c;
    aref_t       a;
    for (int run = 0; run < 3; run++) begin
      do_reset();
      lat = run + 1;
      pr = 1'b0; pg = 1'b0; pd = 1'b0; pa = '0;
      npop = 0;
      for (int i = 0; i < 300; i++) begin
        k_ready = ($urandom % 4) != 0;
        k_gnt   = ($urandom % 3) != 0;
        k_redir = ($urandom % 25) == 0;
        k_rpc   = $urandom;
        step();
        if (pr && !pg && !pd && s_req) begin
          checks++; if (s_addr !== pa)
            begin errors++; $display("FAIL b2b_hold: got %h want %h", s_addr, pa); end
        end
        pr = s_req; pg = s_gnt; pd = s_redir; pa = s_addr;
        while (glog.size() > 0) begin
          a = glog.pop_front();
          checks++; if (a.got !== a.exp)
            begin errors++; $display("FAIL b2b_addr: got %h want %h", a.got, a.exp); end
        end
        while (chk_q.size() > 0) begin
          c = chk_q.pop_front();
          npop++;
          checks++; if (!c.has_exp || c.got !== c.exp)
            begin errors++; $display("FAIL b2b_pair: got %h want %h", c.got, c.exp); end
        end
      end
      k_redir = 1'b0;
      checks++; if (npop < 50)
        begin errors++; $display("FAIL b2b_progress: got %0d pops want >= 50", npop); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_late();
    test_redirect_collide();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
